// File: rtl/pipeline_hazard_controller.sv
// pipeline_hazard_controller: stall/flush/forwarding sequencer for a 5-stage MIPS pipeline.
// Ports:
//   clk, reset                      clock, synchronous active-high reset
//   id_rs, id_rt, id_uses_rs/rt     ID-stage source registers and usage flags
//   ex_rs, ex_rt, ex_dest           EX-stage register fields
//   ex_reg_write, ex_mem_read       EX control bits
//   ex_branch_taken                 branch/jump resolved taken in EX
//   mem_dest, mem_reg_write         MEM-stage writeback info
//   wb_dest, wb_reg_write           WB-stage writeback info
//   dmem_req, dmem_ready            data-memory handshake from MEM
//   pc_en, if_id_en, id_ex_en, ex_mem_en   register load enables (0 = hold)
//   if_id_flush, id_ex_bubble, mem_wb_bubble  register loads NOP
//   fwd_a_sel, fwd_b_sel            00 regfile, 01 EX/MEM, 10 WB
//   mem_timeout                     sticky watchdog flag
//   stall_cycles, flush_count       saturating performance counters
module pipeline_hazard_controller #(
    parameter int MAX_WAIT = 16,
    parameter int CNT_W    = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [4:0]       id_rs,
    input  logic [4:0]       id_rt,
    input  logic             id_uses_rs,
    input  logic             id_uses_rt,
    input  logic [4:0]       ex_rs,
    input  logic [4:0]       ex_rt,
    input  logic [4:0]       ex_dest,
    input  logic             ex_reg_write,
    input  logic             ex_mem_read,
    input  logic             ex_branch_taken,
    input  logic [4:0]       mem_dest,
    input  logic             mem_reg_write,
    input  logic [4:0]       wb_dest,
    input  logic             wb_reg_write,
    input  logic             dmem_req,
    input  logic             dmem_ready,
    output logic             pc_en,
    output logic             if_id_en,
    output logic             id_ex_en,
    output logic             ex_mem_en,
    output logic             if_id_flush,
    output logic             id_ex_bubble,
    output logic             mem_wb_bubble,
    output logic [1:0]       fwd_a_sel,
    output logic [1:0]       fwd_b_sel,
    output logic             mem_timeout,
    output logic [CNT_W-1:0] stall_cycles,
    output logic [7:0]       flush_count
);
    localparam int WW = $clog2(MAX_WAIT + 1);

    typedef enum logic [1:0] {RUN, MEM_WAIT, HALT} state_t;

    state_t        state;
    logic [WW-1:0] wait_cnt;
    logic          freeze, load_use, frz, br, lu;

    function automatic logic [1:0] fwd(input logic [4:0] src, input logic mw, input logic [4:0] md,
                                       input logic ww, input logic [4:0] wd);
        return (mw && md != 5'd0 && md == src) ? 2'b01 :
               (ww && wd != 5'd0 && wd == src) ? 2'b10 : 2'b00;
    endfunction

    assign freeze   = dmem_req && !dmem_ready;
    assign load_use = ex_mem_read && ex_dest != 5'd0 &&
                      ((id_uses_rs && ex_dest == id_rs) || (id_uses_rt && ex_dest == id_rt));

    // HALT keeps the pipeline frozen; a branch seen during a freeze waits because EX is held
    assign frz = !reset && (state == HALT || freeze);
    assign br  = !reset && !frz && ex_branch_taken;
    assign lu  = !reset && !frz && !ex_branch_taken && load_use;

    assign pc_en         = !(frz || lu);
    assign if_id_en      = !(frz || lu);
    assign id_ex_en      = !frz;
    assign ex_mem_en     = !frz;
    assign mem_wb_bubble = frz;
    assign if_id_flush   = br;
    assign id_ex_bubble  = br || lu;
    assign fwd_a_sel     = reset ? 2'b00 : fwd(ex_rs, mem_reg_write, mem_dest, wb_reg_write, wb_dest);
    assign fwd_b_sel     = reset ? 2'b00 : fwd(ex_rt, mem_reg_write, mem_dest, wb_reg_write, wb_dest);

    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= RUN;
            wait_cnt     <= '0;
            mem_timeout  <= 1'b0;
            stall_cycles <= '0;
            flush_count  <= '0;
        end else begin
            if (!pc_en && stall_cycles != {CNT_W{1'b1}})
                stall_cycles <= stall_cycles + 1'b1;
            if (br && flush_count != 8'hff)
                flush_count <= flush_count + 1'b1;
            case (state)
                RUN: if (freeze) begin
                    state    <= MEM_WAIT;
                    wait_cnt <= WW'(1);
                end
                MEM_WAIT: if (!freeze) begin
                    state    <= RUN;
                    wait_cnt <= '0;
                end else if (wait_cnt == WW'(MAX_WAIT - 1)) begin
                    state       <= HALT;
                    mem_timeout <= 1'b1;
                end else begin
                    wait_cnt <= wait_cnt + 1'b1;
                end
                default: ;
            endcase
        end
    end
endmodule
